// File: rtl/codec_cfg_sequencer_if.sv
// rtl/codec_cfg_sequencer_if.sv - request/done handshake between the config sequencer and the I2C write master
interface codec_cfg_sequencer_if;
    logic       i2c_req;
    logic [7:0] i2c_addr;
    logic [7:0] i2c_data1;
    logic [7:0] i2c_data2;
    logic       i2c_done;
    logic       i2c_ack_err;

    modport master (
        output i2c_req,
        output i2c_addr,
        output i2c_data1,
        output i2c_data2,
        input  i2c_done,
        input  i2c_ack_err
    );

    modport slave (
        input  i2c_req,
        input  i2c_addr,
        input  i2c_data1,
        input  i2c_data2,
        output i2c_done,
        output i2c_ack_err
    );
endinterface

// File: rtl/codec_cfg_sequencer.sv
// rtl/codec_cfg_sequencer.sv - walks the WM8731 register table as 3-byte I2C writes with retry, timeout and settling gaps
module codec_cfg_sequencer #(
    parameter logic [7:0] CHIP_ADDR      = 8'h34,
    parameter int         RETRY_MAX      = 3,
    parameter int         GAP_CYCLES     = 1024,
    parameter int         TIMEOUT_CYCLES = 65536
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    codec_cfg_sequencer_if.master        i2c,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         cfg_error,
    output logic [3:0]                   reg_index,
    output logic [1:0]                   retry_cnt
);

    localparam int         GAP_W      = $clog2(GAP_CYCLES) + 1;
    localparam int         TMO_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] LAST_INDEX = 4'd10;
    localparam logic [1:0] RETRY_LIM  = 2'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT_DONE,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       retry_inc;
    logic [15:0]      entry;

    // Table word is {reg_addr[6:0], reg_data[8:0]}, which splits directly into data1/data2.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    table_entry = {7'd15, 9'h000};
            4'd1:    table_entry = {7'd6,  9'h010};
            4'd2:    table_entry = {7'd0,  9'h017};
            4'd3:    table_entry = {7'd1,  9'h017};
            4'd4:    table_entry = {7'd2,  9'h079};
            4'd5:    table_entry = {7'd3,  9'h079};
            4'd6:    table_entry = {7'd4,  9'h012};
            4'd7:    table_entry = {7'd5,  9'h000};
            4'd8:    table_entry = {7'd7,  9'h042};
            4'd9:    table_entry = {7'd8,  9'h000};
            4'd10:   table_entry = {7'd9,  9'h001};
            default: table_entry = 16'h0000;
        endcase
    endfunction

    assign entry     = table_entry(reg_index);
    assign retry_inc = retry_cnt + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            i2c.i2c_req   <= 1'b0;
            i2c.i2c_addr  <= 8'h00;
            i2c.i2c_data1 <= 8'h00;
            i2c.i2c_data2 <= 8'h00;
            cfg_busy      <= 1'b0;
            cfg_done      <= 1'b0;
            cfg_error     <= 1'b0;
            reg_index     <= 4'd0;
            retry_cnt     <= 2'd0;
            gap_cnt       <= '0;
            tmo_cnt       <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state     <= S_LOAD;
                        reg_index <= 4'd0;
                        retry_cnt <= 2'd0;
                        cfg_busy  <= 1'b1;
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
                    end
                end
                S_LOAD: begin
                    i2c.i2c_addr  <= CHIP_ADDR;
                    i2c.i2c_data1 <= entry[15:8];
                    i2c.i2c_data2 <= entry[7:0];
                    i2c.i2c_req   <= 1'b1;
                    state         <= S_REQ;
                end
                S_REQ: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // A done pulse wins over a timeout expiring in the same cycle.
                    if (i2c.i2c_done && !i2c.i2c_ack_err) begin
                        i2c.i2c_req <= 1'b0;
                        retry_cnt   <= 2'd0;
                        if (reg_index == LAST_INDEX) begin
                            state    <= S_DONE;
                            cfg_busy <= 1'b0;
                            cfg_done <= 1'b1;
                        end else begin
                            reg_index <= reg_index + 4'd1;
                            gap_cnt   <= '0;
                            state     <= S_GAP;
                        end
                    end else if (i2c.i2c_done || (tmo_cnt == TMO_LAST)) begin
                        i2c.i2c_req <= 1'b0;
                        retry_cnt   <= retry_inc;
                        if (retry_inc == RETRY_LIM) begin
                            state     <= S_ERROR;
                            cfg_busy  <= 1'b0;
                            cfg_error <= 1'b1;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb/tb_codec_cfg_sequencer.sv - randomized slave responses checked against a table-level reference model
module tb_codec_cfg_sequencer;

    localparam int GAP  = 16;
    localparam int TMO  = 64;
    localparam int RMAX = 3;
    localparam int CHIP = 'h34;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_error;
    logic [3:0] reg_index;
    logic [1:0] retry_cnt;

    int checks   = 0;
    int failures = 0;

    int ref_addr [11] = '{15, 6, 0, 1, 2, 3, 4, 5, 7, 8, 9};
    int ref_data [11] = '{'h000, 'h010, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h042, 'h000, 'h001};

    codec_cfg_sequencer_if bus ();

    codec_cfg_sequencer #(
        .CHIP_ADDR      (8'h34),
        .RETRY_MAX      (RMAX),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .i2c       (bus),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .reg_index (reg_index),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_payload(input string tag, input int idx);
        check({tag, "_addr"},  bus.i2c_addr, CHIP);
        check({tag, "_data1"}, bus.i2c_data1, ((ref_addr[idx] * 2) + (ref_data[idx] / 256)) % 256);
        check({tag, "_data2"}, bus.i2c_data2, ref_data[idx] % 256);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   bus.i2c_req, 0);
        check({tag, "_addr"},  bus.i2c_addr, 0);
        check({tag, "_data1"}, bus.i2c_data1, 0);
        check({tag, "_data2"}, bus.i2c_data2, 0);
        check({tag, "_busy"},  cfg_busy, 0);
        check({tag, "_done"},  cfg_done, 0);
        check({tag, "_error"}, cfg_error, 0);
        check({tag, "_index"}, reg_index, 0);
        check({tag, "_retry"}, retry_cnt, 0);
    endtask

    // Counts negedges with req low (current one included), throwing stray done/start pulses at the DUT.
    task automatic wait_req(output int low);
        low = 0;
        while (bus.i2c_req !== 1'b1 && low < GAP + 40) begin
            low++;
            bus.i2c_done    = ($urandom_range(0, 3) == 0);
            bus.i2c_ack_err = 1'($urandom_range(0, 1));
            start           = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            bus.i2c_done    = 1'b0;
            bus.i2c_ack_err = 1'b0;
            start           = 1'b0;
        end
        check("req_arrives", bus.i2c_req, 1);
    endtask

    task automatic run_seq(input int fail_idx, input int fail_times, input bit use_tmo,
                           input int edge_idx, input int abort_idx);
        int  idx;
        int  retries;
        int  fails_here;
        int  low;
        int  hi;
        int  d;
        bit  fail;
        idx        = 0;
        retries    = 0;
        fails_here = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", cfg_busy, 1);
        check("done_cleared", cfg_done, 0);
        check("error_cleared", cfg_error, 0);
        wait_req(low);
        check("start_latency", low + 1, 2);
        for (int guard = 0; guard < 40; guard++) begin
            check_payload("req_payload", idx);
            check("req_index", reg_index, idx);
            check("req_retry", retry_cnt, retries);
            check("req_busy", cfg_busy, 1);
            if (idx == abort_idx) begin
                repeat (3) @(negedge clk);
                #2 reset = 1'b1;
                #1 check_all_zero("async_reset");
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                check("post_reset_busy", cfg_busy, 0);
                return;
            end
            fail = (idx == fail_idx) && (fails_here < fail_times);
            if (fail && use_tmo) begin
                hi = 1;
                for (int k = 0; k < TMO + 10; k++) begin
                    start = ($urandom_range(0, 7) == 0);
                    @(negedge clk);
                    start = 1'b0;
                    if (bus.i2c_req !== 1'b1) break;
                    hi++;
                end
                // REQ cycle plus TIMEOUT_CYCLES cycles in WAIT_DONE
                check("timeout_req_cycles", hi, TMO + 1);
            end else begin
                d = (idx == edge_idx && !fail) ? TMO - 1 : int'($urandom_range(1, 30));
                repeat (d) begin
                    start = ($urandom_range(0, 7) == 0);
                    @(negedge clk);
                    start = 1'b0;
                end
                check_payload("held_payload", idx);
                check("held_req", bus.i2c_req, 1);
                bus.i2c_done    = 1'b1;
                bus.i2c_ack_err = fail;
                start           = 1'($urandom_range(0, 1));
                @(negedge clk);
                bus.i2c_done    = 1'b0;
                bus.i2c_ack_err = 1'b0;
                start           = 1'b0;
                check("req_dropped", bus.i2c_req, 0);
            end
            if (fail) begin
                fails_here++;
                retries++;
                if (retries == RMAX) begin
                    check("err_flag", cfg_error, 1);
                    check("err_busy", cfg_busy, 0);
                    check("err_done", cfg_done, 0);
                    check("err_index", reg_index, idx);
                    check("err_retry", retry_cnt, RMAX);
                    check("err_req", bus.i2c_req, 0);
                    return;
                end
            end else begin
                retries = 0;
                if (idx == 10) begin
                    check("done_flag", cfg_done, 1);
                    check("done_busy", cfg_busy, 0);
                    check("done_index", reg_index, 10);
                    check("done_retry", retry_cnt, 0);
                    bus.i2c_done = 1'b1;
                    @(negedge clk);
                    bus.i2c_done = 1'b0;
                    @(negedge clk);
                    check("done_sticky", cfg_done, 1);
                    check("done_req_idle", bus.i2c_req, 0);
                    return;
                end
                idx++;
                fails_here = 0;
            end
            check("post_index", reg_index, idx);
            check("post_retry", retry_cnt, retries);
            wait_req(low);
            // GAP_CYCLES in GAP plus the LOAD cycle
            check("gap_idle_cycles", low, GAP + 1);
        end
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        bus.i2c_done    = 1'b0;
        bus.i2c_ack_err = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        run_seq(-1, 0, 1'b0, 7, -1);
        run_seq(2, 1, 1'b0, -1, -1);
        run_seq(5, 3, 1'b0, -1, -1);
        run_seq(0, 3, 1'b1, -1, -1);
        run_seq(-1, 0, 1'b0, -1, 4);
        run_seq(3, 2, 1'b1, -1, -1);
        repeat (4) begin
            run_seq(int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 10)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
- Upstream feeder for the I2C write master on the DE10-Standard audio path.
- On a start pulse, walks a fixed 11-entry WM8731 register table (chip address 0x34).
- For each entry, presents one 3-byte write transaction (address, data1, data2) to the I2C master over a req/done handshake.
- Handles NACK retries, a done-timeout and inter-write settling gaps, then reports done or error to top-level control.

Parameters:
- CHIP_ADDR, 8'h34: 8-bit write address byte driven on i2c_addr.
- RETRY_MAX, 3: failed attempts allowed per entry before ERROR.
- GAP_CYCLES, 1024: clk cycles idle after every completed or failed transaction before the next request.
- TIMEOUT_CYCLES, 65536: clk cycles in WAIT_DONE without i2c_done before the attempt counts as a failure.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins/restarts the sequence (honoured only in IDLE, DONE, ERROR).
- i2c_req  out  1  transaction request to I2C master.
- i2c_addr  out  8  chip address byte; always CHIP_ADDR.
- i2c_data1  out  8  {reg_addr[6:0], reg_data[8]}.
- i2c_data2  out  8  reg_data[7:0].
- i2c_done  in  1  single-cycle pulse from master: transaction finished.
- i2c_ack_err  in  1  qualified by i2c_done; 1 = any NACK received.
- cfg_busy  out  1  high in every state except IDLE, DONE, ERROR.
- cfg_done  out  1  high while in DONE.
- cfg_error  out  1  high while in ERROR.
- reg_index  out  4  table entry currently being written (0..10).
- retry_cnt  out  2  failed attempts on the current entry.

Behaviour:
Register table, index: reg addr / 9-bit data:
- 0: R15 / 0x000
- 1: R6 / 0x010
- 2: R0 / 0x017
- 3: R1 / 0x017
- 4: R2 / 0x079
- 5: R3 / 0x079
- 6: R4 / 0x012
- 7: R5 / 0x000
- 8: R7 / 0x042
- 9: R8 / 0x000
- 10: R9 / 0x001

Reset:
- All outputs 0; state IDLE; reg_index 0; retry_cnt 0; gap and timeout counters 0.
- Reset mid-transaction drops i2c_req asynchronously. No completion is waited for.

State machine:
- IDLE: start -> LOAD with reg_index=0, retry_cnt=0.
- LOAD, 1 cycle: register i2c_data1/i2c_data2 from table[reg_index] -> REQ.
- REQ: i2c_req=1 -> WAIT_DONE next cycle. i2c_req stays high through WAIT_DONE.
- WAIT_DONE:
  - Payload held stable; timeout counter increments each cycle.
  - i2c_done & !i2c_ack_err: drop req, retry_cnt=0. If reg_index==10 -> DONE; else reg_index+1 -> GAP.
  - i2c_done & i2c_ack_err, or timeout counter reaches TIMEOUT_CYCLES-1: drop req, retry_cnt+1. If new retry_cnt==RETRY_MAX -> ERROR (reg_index frozen at failing entry); else -> GAP with the same reg_index.
- GAP: count GAP_CYCLES cycles, then -> LOAD. The counter is cleared on entry.
- DONE / ERROR: terminal. A start pulse -> LOAD with reg_index=0, retry_cnt=0, cfg_done/cfg_error cleared the same edge.

Handshake and edge cases:
- i2c_req is registered. It deasserts the cycle after i2c_done is sampled and never re-asserts without passing through GAP and LOAD.
- i2c_done outside WAIT_DONE is ignored.
- start while cfg_busy is ignored.
- start coincident with i2c_done in WAIT_DONE: done is processed, start is ignored.
- i2c_done arriving on the same cycle the timeout expires: i2c_done takes priority.
- Latency, start to first i2c_req: 2 cycles (LOAD, REQ).
- Best-case full sequence: 11 transactions plus 10 gaps.

Test Plan:
- Reset, start pulse, slave model returns done with ack_err=0 after 30 cycles each -> 11 requests in order; first payload is 0x34/0x1E/0x00; last is 0x34/0x12/0x01; cfg_done=1, cfg_busy=0, reg_index=10.
- NACK once on index 2, then ACK -> index 2 re-requested after exactly GAP_CYCLES idle cycles with an identical payload (0x34/0x00/0x17); retry_cnt returns to 0; sequence completes.
- NACK 3 times on index 5 -> ERROR, cfg_error=1, reg_index=5, retry_cnt=3, i2c_req=0; then start -> restarts at index 0 with payload 0x1E/0x00.
- Model never returns done -> i2c_req drops after TIMEOUT_CYCLES; three timeouts -> ERROR at index 0.
- Assert reset while waiting on index 4 -> i2c_req=0 within the reset cycle, all outputs 0; after release, start -> restarts at index 0.
- start pulses during busy, plus i2c_done pulses injected in GAP -> no effect on index, requests or counters.
